// File: rtl/dat_xfer_sequencer_if.sv
// Handshake/configuration bundle between the register file/FIFO side and the DAT
// transfer sequencer. The master drives transfer requests; the slave is the sequencer.
interface dat_xfer_sequencer_if #(
    parameter int unsigned BLK_SIZE_W = 12,
    parameter int unsigned BLK_CNT_W  = 16,
    parameter int unsigned TMO_W      = 16
) ();
    logic                  start;
    logic                  dir_read;
    logic                  multi_blk;
    logic                  blk_cnt_en;
    logic                  auto_cmd12_en;
    logic [BLK_SIZE_W-1:0] blk_size;
    logic [BLK_CNT_W-1:0]  blk_count;
    logic [TMO_W-1:0]      timeout_val;
    logic                  soft_reset;
    logic                  stop_req;
    logic                  fifo_ready;
    logic                  blk_done;
    logic                  blk_crc_ok;
    logic                  dat0_busy;
    logic                  cmd12_ack;

    logic                  blk_start;
    logic [BLK_SIZE_W-1:0] blk_len;
    logic                  xfer_active;
    logic                  xfer_done;
    logic                  cmd12_req;
    logic                  crc_err;
    logic                  timeout_err;
    logic [BLK_CNT_W-1:0]  blocks_left;

    modport master (
        output start, dir_read, multi_blk, blk_cnt_en, auto_cmd12_en, blk_size, blk_count,
               timeout_val, soft_reset, stop_req, fifo_ready, blk_done, blk_crc_ok, dat0_busy,
               cmd12_ack,
        input  blk_start, blk_len, xfer_active, xfer_done, cmd12_req, crc_err, timeout_err,
               blocks_left
    );

    modport slave (
        input  start, dir_read, multi_blk, blk_cnt_en, auto_cmd12_en, blk_size, blk_count,
               timeout_val, soft_reset, stop_req, fifo_ready, blk_done, blk_crc_ok, dat0_busy,
               cmd12_ack,
        output blk_start, blk_len, xfer_active, xfer_done, cmd12_req, crc_err, timeout_err,
               blocks_left
    );
endinterface

// File: rtl/dat_xfer_sequencer.sv
// Block-level DAT transfer sequencer: paces the DAT engine one block at a time,
// tracks remaining blocks, waits out write busy, enforces timeout, requests auto CMD12.
module dat_xfer_sequencer #(
    parameter int unsigned BLK_SIZE_W = 12,
    parameter int unsigned BLK_CNT_W  = 16,
    parameter int unsigned TMO_W      = 16
) (
    input logic                clk,
    input logic                reset_n,
    dat_xfer_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        StIdle,
        StWaitFifo,
        StBlock,
        StWaitBusy,
        StStopCmd,
        StDone
    } state_e;

    state_e                state_q, state_d;
    logic                  dir_read_q, dir_read_d;
    logic                  multi_blk_q, multi_blk_d;
    logic                  blk_cnt_en_q, blk_cnt_en_d;
    logic                  auto_cmd12_q, auto_cmd12_d;
    logic [BLK_SIZE_W-1:0] blk_len_q, blk_len_d;
    logic [BLK_CNT_W-1:0]  blocks_left_q, blocks_left_d;
    logic [TMO_W-1:0]      tmo_q, tmo_d;
    logic                  blk_start_q, blk_start_d;
    logic                  xfer_active_q, xfer_active_d;
    logic                  xfer_done_q, xfer_done_d;
    logic                  cmd12_req_q, cmd12_req_d;
    logic                  crc_err_q, crc_err_d;
    logic                  timeout_err_q, timeout_err_d;

    logic                  tmo_expired;
    logic                  go_end;
    logic [BLK_CNT_W-1:0]  blocks_after;
    logic                  last_after_blk;
    logic                  last_after_busy;

    always_comb begin
        state_d       = state_q;
        dir_read_d    = dir_read_q;
        multi_blk_d   = multi_blk_q;
        blk_cnt_en_d  = blk_cnt_en_q;
        auto_cmd12_d  = auto_cmd12_q;
        blk_len_d     = blk_len_q;
        blocks_left_d = blocks_left_q;
        crc_err_d     = crc_err_q;
        timeout_err_d = timeout_err_q;
        tmo_d         = (tmo_q != '0) ? tmo_q - TMO_W'(1) : tmo_q;
        go_end        = 1'b0;

        // A loaded value of 0 never reaches 1, so a zero timeout stays disabled.
        tmo_expired     = (tmo_q == TMO_W'(1));
        blocks_after    = (blk_cnt_en_q && blocks_left_q != '0) ?
                          blocks_left_q - BLK_CNT_W'(1) : blocks_left_q;
        last_after_blk  = !multi_blk_q || (blk_cnt_en_q && blocks_after == '0) || bus.stop_req;
        last_after_busy = !multi_blk_q || (blk_cnt_en_q && blocks_left_q == '0) ||
                          bus.stop_req;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    dir_read_d    = bus.dir_read;
                    multi_blk_d   = bus.multi_blk;
                    blk_cnt_en_d  = bus.blk_cnt_en;
                    auto_cmd12_d  = bus.auto_cmd12_en;
                    blk_len_d     = bus.blk_size;
                    blocks_left_d = bus.blk_count;
                    crc_err_d     = 1'b0;
                    timeout_err_d = 1'b0;
                    state_d       = (bus.blk_cnt_en && bus.blk_count == '0) ? StDone : StWaitFifo;
                end
            end
            StWaitFifo: begin
                if (bus.fifo_ready) state_d = StBlock;
            end
            StBlock: begin
                // Block completion takes priority over a coincident timeout.
                if (bus.blk_done) begin
                    if (!bus.blk_crc_ok) begin
                        crc_err_d = 1'b1;
                        go_end    = 1'b1;
                    end else begin
                        blocks_left_d = blocks_after;
                        if (!dir_read_q)        state_d = StWaitBusy;
                        else if (last_after_blk) go_end  = 1'b1;
                        else                    state_d = StWaitFifo;
                    end
                end else if (tmo_expired) begin
                    timeout_err_d = 1'b1;
                    go_end        = 1'b1;
                end
            end
            StWaitBusy: begin
                if (!bus.dat0_busy) begin
                    if (last_after_busy) go_end  = 1'b1;
                    else                 state_d = StWaitFifo;
                end else if (tmo_expired) begin
                    timeout_err_d = 1'b1;
                    go_end        = 1'b1;
                end
            end
            StStopCmd: begin
                if (bus.cmd12_ack) state_d = StDone;
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (go_end) state_d = (multi_blk_q && auto_cmd12_q) ? StStopCmd : StDone;

        if (state_d != state_q && (state_d == StBlock || state_d == StWaitBusy)) begin
            tmo_d = bus.timeout_val;
        end

        if (bus.soft_reset) begin
            state_d       = StIdle;
            crc_err_d     = 1'b0;
            timeout_err_d = 1'b0;
            blocks_left_d = '0;
            tmo_d         = '0;
        end

        // Registered outputs are derived from the committed next state.
        blk_start_d   = (state_q == StWaitFifo) && (state_d == StBlock);
        xfer_done_d   = (state_d == StDone) && (state_q != StDone);
        cmd12_req_d   = (state_d == StStopCmd);
        xfer_active_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            dir_read_q    <= 1'b0;
            multi_blk_q   <= 1'b0;
            blk_cnt_en_q  <= 1'b0;
            auto_cmd12_q  <= 1'b0;
            blk_len_q     <= '0;
            blocks_left_q <= '0;
            tmo_q         <= '0;
            blk_start_q   <= 1'b0;
            xfer_active_q <= 1'b0;
            xfer_done_q   <= 1'b0;
            cmd12_req_q   <= 1'b0;
            crc_err_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            dir_read_q    <= dir_read_d;
            multi_blk_q   <= multi_blk_d;
            blk_cnt_en_q  <= blk_cnt_en_d;
            auto_cmd12_q  <= auto_cmd12_d;
            blk_len_q     <= blk_len_d;
            blocks_left_q <= blocks_left_d;
            tmo_q         <= tmo_d;
            blk_start_q   <= blk_start_d;
            xfer_active_q <= xfer_active_d;
            xfer_done_q   <= xfer_done_d;
            cmd12_req_q   <= cmd12_req_d;
            crc_err_q     <= crc_err_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign bus.blk_start   = blk_start_q;
    assign bus.blk_len     = blk_len_q;
    assign bus.xfer_active = xfer_active_q;
    assign bus.xfer_done   = xfer_done_q;
    assign bus.cmd12_req   = cmd12_req_q;
    assign bus.crc_err     = crc_err_q;
    assign bus.timeout_err = timeout_err_q;
    assign bus.blocks_left = blocks_left_q;

endmodule

// File: tb/tb_dat_xfer_sequencer.sv
// Directed self-checking bench for dat_xfer_sequencer.
module tb_dat_xfer_sequencer;

    localparam int unsigned BW = 12;
    localparam int unsigned CW = 16;
    localparam int unsigned TW = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    dat_xfer_sequencer_if #(.BLK_SIZE_W(BW), .BLK_CNT_W(CW), .TMO_W(TW)) bus ();

    dat_xfer_sequencer #(.BLK_SIZE_W(BW), .BLK_CNT_W(CW), .TMO_W(TW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    int n_bs   = 0;
    int n_done = 0;
    int base_bs, base_done;
    bit seen;

    always @(negedge clk) begin
        if (bus.blk_start === 1'b1) n_bs++;
        if (bus.xfer_done === 1'b1) n_done++;
    end

    task automatic init_inputs();
        bus.start = 0; bus.dir_read = 0; bus.multi_blk = 0; bus.blk_cnt_en = 0;
        bus.auto_cmd12_en = 0; bus.blk_size = '0; bus.blk_count = '0; bus.timeout_val = '0;
        bus.soft_reset = 0; bus.stop_req = 0; bus.fifo_ready = 0; bus.blk_done = 0;
        bus.blk_crc_ok = 0; bus.dat0_busy = 0; bus.cmd12_ack = 0;
    endtask

    task automatic cfg(input bit rd, input bit multi, input bit cnt_en, input bit auto12,
                       input logic [BW-1:0] size, input logic [CW-1:0] cnt,
                       input logic [TW-1:0] tmo);
        bus.dir_read = rd; bus.multi_blk = multi; bus.blk_cnt_en = cnt_en;
        bus.auto_cmd12_en = auto12; bus.blk_size = size; bus.blk_count = cnt;
        bus.timeout_val = tmo;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
    endtask

    // Returns at the negedge where blk_start is seen, or after a bounded budget.
    task automatic wait_blk_start(output bit found);
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.blk_start === 1'b1) begin found = 1'b1; break; end
        end
    endtask

    task automatic wait_cmd12(output bit found);
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.cmd12_req === 1'b1) begin found = 1'b1; break; end
        end
    endtask

    task automatic finish_block(input bit crc_ok);
        bus.blk_done = 1'b1; bus.blk_crc_ok = crc_ok;
        @(posedge clk); #1 bus.blk_done = 1'b0; bus.blk_crc_ok = 1'b1;
    endtask

    task automatic test_reset();
        init_inputs();
        #12;
        checks++;
        if ({bus.blk_start, bus.xfer_active, bus.xfer_done, bus.cmd12_req, bus.crc_err,
             bus.timeout_err} !== 6'b0) begin
            errors++; $display("FAIL reset_flags got %b want 000000", {bus.blk_start,
                bus.xfer_active, bus.xfer_done, bus.cmd12_req, bus.crc_err, bus.timeout_err});
        end
        checks++;
        if (bus.blocks_left !== '0) begin
            errors++; $display("FAIL reset_blocks_left got %0d want 0", bus.blocks_left);
        end
        checks++;
        if (bus.blk_len !== '0) begin
            errors++; $display("FAIL reset_blk_len got %0d want 0", bus.blk_len);
        end
        @(negedge clk); reset_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.xfer_active !== 1'b0) begin
            errors++; $display("FAIL idle_active got %b want 0", bus.xfer_active);
        end
    endtask

    task automatic test_single_read();
        cfg(1, 0, 0, 0, 12'd512, 16'd1, 16'd0);
        bus.fifo_ready = 1'b1;
        base_bs = n_bs; base_done = n_done;
        @(negedge clk); pulse_start();
        @(negedge clk);
        checks++;
        if (bus.xfer_active !== 1'b1) begin
            errors++; $display("FAIL sr_active got %b want 1", bus.xfer_active);
        end
        checks++;
        if (bus.blk_len !== 12'd512) begin
            errors++; $display("FAIL sr_blk_len got %0d want 512", bus.blk_len);
        end
        wait_blk_start(seen);
        checks++;
        if (!seen) begin errors++; $display("FAIL sr_blk_start got 0 want 1"); end
        finish_block(1'b1);
        @(negedge clk);
        checks++;
        if (bus.xfer_done !== 1'b1 || bus.cmd12_req !== 1'b0) begin
            errors++; $display("FAIL sr_done got done=%b cmd12=%b want done=1 cmd12=0",
                               bus.xfer_done, bus.cmd12_req);
        end
        @(negedge clk);
        checks++;
        if (bus.xfer_done !== 1'b0 || bus.xfer_active !== 1'b0) begin
            errors++; $display("FAIL sr_drop got done=%b active=%b want 0 0",
                               bus.xfer_done, bus.xfer_active);
        end
        bus.fifo_ready = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (n_bs - base_bs != 1 || n_done - base_done != 1) begin
            errors++; $display("FAIL sr_counts got starts=%0d dones=%0d want 1 1",
                               n_bs - base_bs, n_done - base_done);
        end
    endtask

    task automatic test_multi_write();
        cfg(0, 1, 1, 1, 12'd64, 16'd3, 16'd0);
        bus.fifo_ready = 1'b1;
        base_bs = n_bs; base_done = n_done;
        @(negedge clk); pulse_start();
        for (int i = 0; i < 3; i++) begin
            wait_blk_start(seen);
            checks++;
            if (!seen || bus.blocks_left !== CW'(3 - i)) begin
                errors++; $display("FAIL mw_blk%0d_pre got seen=%b left=%0d want 1 %0d",
                                   i, seen, bus.blocks_left, 3 - i);
            end
            bus.dat0_busy = 1'b1;
            finish_block(1'b1);
            repeat (4) @(posedge clk);
            #1 bus.dat0_busy = 1'b0;
            @(negedge clk);
            checks++;
            if (bus.blocks_left !== CW'(2 - i)) begin
                errors++; $display("FAIL mw_blk%0d_post got %0d want %0d",
                                   i, bus.blocks_left, 2 - i);
            end
        end
        wait_cmd12(seen);
        checks++;
        if (!seen) begin errors++; $display("FAIL mw_cmd12_req got 0 want 1"); end
        repeat (3) @(negedge clk);
        checks++;
        if (bus.cmd12_req !== 1'b1 || bus.xfer_done !== 1'b0) begin
            errors++; $display("FAIL mw_cmd12_hold got req=%b done=%b want 1 0",
                               bus.cmd12_req, bus.xfer_done);
        end
        bus.cmd12_ack = 1'b1;
        @(posedge clk); #1 bus.cmd12_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.xfer_done !== 1'b1 || bus.cmd12_req !== 1'b0) begin
            errors++; $display("FAIL mw_done got done=%b req=%b want 1 0",
                               bus.xfer_done, bus.cmd12_req);
        end
        bus.fifo_ready = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (n_bs - base_bs != 3) begin
            errors++; $display("FAIL mw_starts got %0d want 3", n_bs - base_bs);
        end
    endtask

    task automatic test_crc_fail();
        cfg(1, 1, 1, 1, 12'd256, 16'd4, 16'd0);
        bus.fifo_ready = 1'b1;
        base_bs = n_bs; base_done = n_done;
        @(negedge clk); pulse_start();
        wait_blk_start(seen);
        finish_block(1'b1);
        wait_blk_start(seen);
        checks++;
        if (!seen) begin errors++; $display("FAIL crc_blk2_start got 0 want 1"); end
        finish_block(1'b0);
        @(negedge clk);
        checks++;
        if (bus.crc_err !== 1'b1 || bus.blocks_left !== 16'd3 || bus.cmd12_req !== 1'b1) begin
            errors++; $display("FAIL crc_state got err=%b left=%0d req=%b want 1 3 1",
                               bus.crc_err, bus.blocks_left, bus.cmd12_req);
        end
        repeat (3) @(negedge clk);
        bus.cmd12_ack = 1'b1;
        @(posedge clk); #1 bus.cmd12_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.xfer_done !== 1'b1 || bus.crc_err !== 1'b1) begin
            errors++; $display("FAIL crc_done got done=%b err=%b want 1 1",
                               bus.xfer_done, bus.crc_err);
        end
        bus.fifo_ready = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (n_bs - base_bs != 2) begin
            errors++; $display("FAIL crc_starts got %0d want 2", n_bs - base_bs);
        end
    endtask

    task automatic test_timeout();
        cfg(1, 0, 0, 0, 12'd16, 16'd1, 16'd10);
        bus.fifo_ready = 1'b1;
        @(negedge clk); pulse_start();
        wait_blk_start(seen);
        repeat (9) @(negedge clk);
        checks++;
        if (bus.timeout_err !== 1'b0) begin
            errors++; $display("FAIL tmo_early got %b want 0", bus.timeout_err);
        end
        @(negedge clk);
        checks++;
        if (bus.timeout_err !== 1'b1 || bus.xfer_done !== 1'b1) begin
            errors++; $display("FAIL tmo_fire got err=%b done=%b want 1 1",
                               bus.timeout_err, bus.xfer_done);
        end
        @(negedge clk);
        cfg(1, 0, 0, 0, 12'd16, 16'd1, 16'd0);
        pulse_start();
        @(negedge clk);
        checks++;
        if (bus.timeout_err !== 1'b0) begin
            errors++; $display("FAIL tmo_clear_on_start got %b want 0", bus.timeout_err);
        end
        wait_blk_start(seen);
        repeat (1000) @(negedge clk);
        checks++;
        if (bus.timeout_err !== 1'b0 || bus.xfer_active !== 1'b1) begin
            errors++; $display("FAIL tmo_disabled got err=%b active=%b want 0 1",
                               bus.timeout_err, bus.xfer_active);
        end
        finish_block(1'b1);
        @(negedge clk);
        checks++;
        if (bus.xfer_done !== 1'b1) begin
            errors++; $display("FAIL tmo_disabled_done got %b want 1", bus.xfer_done);
        end
        bus.fifo_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_boundaries();
        cfg(1, 1, 1, 1, 12'd32, 16'd0, 16'd0);
        bus.fifo_ready = 1'b1;
        base_bs = n_bs;
        @(negedge clk); pulse_start();
        @(negedge clk);
        checks++;
        if (bus.xfer_done !== 1'b1 || bus.xfer_active !== 1'b1) begin
            errors++; $display("FAIL zero_cnt_done got done=%b active=%b want 1 1",
                               bus.xfer_done, bus.xfer_active);
        end
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        checks++;
        if (n_bs - base_bs != 0) begin
            errors++; $display("FAIL zero_cnt_starts got %0d want 0", n_bs - base_bs);
        end

        cfg(1, 0, 0, 0, 12'd32, 16'd1, 16'd4);
        @(negedge clk); pulse_start();
        wait_blk_start(seen);
        repeat (3) @(negedge clk);
        finish_block(1'b1);
        @(negedge clk);
        checks++;
        if (bus.timeout_err !== 1'b0 || bus.xfer_done !== 1'b1) begin
            errors++; $display("FAIL done_vs_tmo got err=%b done=%b want 0 1",
                               bus.timeout_err, bus.xfer_done);
        end

        bus.fifo_ready = 1'b0;
        cfg(1, 1, 1, 0, 12'd100, 16'd2, 16'd0);
        @(negedge clk); pulse_start();
        @(negedge clk);
        cfg(1, 1, 1, 0, 12'd200, 16'd7, 16'd0);
        pulse_start();
        @(negedge clk);
        checks++;
        if (bus.blk_len !== 12'd100 || bus.blocks_left !== 16'd2 || bus.xfer_active !== 1'b1)
        begin
            errors++; $display("FAIL start_ignored got len=%0d left=%0d act=%b want 100 2 1",
                               bus.blk_len, bus.blocks_left, bus.xfer_active);
        end
        base_bs = n_bs;
        bus.stop_req = 1'b1; bus.fifo_ready = 1'b1;
        wait_blk_start(seen);
        finish_block(1'b1);
        @(negedge clk);
        checks++;
        if (bus.xfer_done !== 1'b1 || bus.blocks_left !== 16'd1) begin
            errors++; $display("FAIL stop_req got done=%b left=%0d want 1 1",
                               bus.xfer_done, bus.blocks_left);
        end
        bus.stop_req = 1'b0; bus.fifo_ready = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (n_bs - base_bs != 1) begin
            errors++; $display("FAIL stop_req_starts got %0d want 1", n_bs - base_bs);
        end
    endtask

    task automatic test_aborts();
        cfg(0, 1, 1, 1, 12'd64, 16'd5, 16'd0);
        bus.fifo_ready = 1'b1;
        base_done = n_done;
        @(negedge clk); pulse_start();
        wait_blk_start(seen);
        finish_block(1'b1);
        wait_blk_start(seen);
        bus.soft_reset = 1'b1;
        @(posedge clk); #1 bus.soft_reset = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.xfer_active !== 1'b0 || bus.blocks_left !== '0 || bus.cmd12_req !== 1'b0 ||
            bus.crc_err !== 1'b0 || bus.timeout_err !== 1'b0) begin
            errors++; $display("FAIL soft_reset got act=%b left=%0d req=%b crc=%b tmo=%b want 0",
                bus.xfer_active, bus.blocks_left, bus.cmd12_req, bus.crc_err, bus.timeout_err);
        end
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        checks++;
        if (n_done - base_done != 0) begin
            errors++; $display("FAIL soft_reset_no_done got %0d want 0", n_done - base_done);
        end

        cfg(1, 0, 0, 0, 12'd16, 16'd1, 16'd2);
        @(negedge clk); pulse_start();
        wait_blk_start(seen);
        repeat (3) @(negedge clk);
        checks++;
        if (bus.timeout_err !== 1'b1) begin
            errors++; $display("FAIL sticky_tmo got %b want 1", bus.timeout_err);
        end
        bus.soft_reset = 1'b1;
        @(posedge clk); #1 bus.soft_reset = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.timeout_err !== 1'b0) begin
            errors++; $display("FAIL soft_reset_clears got %b want 0", bus.timeout_err);
        end

        cfg(1, 1, 1, 1, 12'd64, 16'd1, 16'd0);
        @(negedge clk); pulse_start();
        wait_blk_start(seen);
        finish_block(1'b1);
        @(negedge clk);
        checks++;
        if (bus.cmd12_req !== 1'b1) begin
            errors++; $display("FAIL pre_reset_req got %b want 1", bus.cmd12_req);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (bus.cmd12_req !== 1'b0 || bus.xfer_active !== 1'b0 || bus.blk_len !== '0) begin
            errors++; $display("FAIL async_reset got req=%b act=%b len=%0d want 0 0 0",
                               bus.cmd12_req, bus.xfer_active, bus.blk_len);
        end
        bus.fifo_ready = 1'b0;
        @(negedge clk); reset_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_read();
        test_multi_write();
        test_crc_fail();
        test_timeout();
        test_boundaries();
        test_aborts();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dat_xfer_sequencer.md
# dat_xfer_sequencer

Sequences block-level DAT-line transfers for the SD host. It latches the transfer-mode configuration at command acceptance and paces the DAT engine one block at a time against FIFO readiness. It tracks the remaining block count, waits out write busy, enforces a data timeout, and requests an auto CMD12 at the end of multi-block transfers. It sits between the register file/FIFO and the DAT communication engine, on the system clock.

## Interface
- BLK_SIZE_W, 12, width of block length in bytes
- BLK_CNT_W, 16, width of block count
- TMO_W, 16, width of timeout counter
- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse: data command accepted, begin transfer
- dir_read  in  1  1 = card->host, 0 = host->card
- multi_blk  in  1  multiple-block mode
- blk_cnt_en  in  1  block count enable
- auto_cmd12_en  in  1  issue CMD12 after multi-block transfer
- blk_size  in  BLK_SIZE_W  bytes per block
- blk_count  in  BLK_CNT_W  blocks to transfer
- timeout_val  in  TMO_W  data timeout in clk cycles, 0 = disabled
- soft_reset  in  1  synchronous abort of DAT logic
- stop_req  in  1  level: stop at next block boundary
- fifo_ready  in  1  write: one full block buffered; read: one block of space free
- blk_done  in  1  pulse from DAT engine: block finished
- blk_crc_ok  in  1  CRC status, valid with blk_done
- dat0_busy  in  1  card holding DAT0 low after write
- cmd12_ack  in  1  CMD12 issued by command path
- blk_start  out  1  one-cycle pulse: DAT engine starts one block
- blk_len  out  BLK_SIZE_W  latched blk_size
- xfer_active  out  1  high from accepted start until DONE exits
- xfer_done  out  1  one-cycle completion pulse
- cmd12_req  out  1  held until cmd12_ack
- crc_err  out  1  sticky
- timeout_err  out  1  sticky
- blocks_left  out  BLK_CNT_W  remaining block count

## Operation
- States: IDLE, WAIT_FIFO, BLOCK, WAIT_BUSY, STOP_CMD, DONE.
- IDLE: start latches dir_read, multi_blk, blk_cnt_en, auto_cmd12_en, blk_size (to blk_len), blk_count (to blocks_left), and clears crc_err/timeout_err. Go to DONE if blk_cnt_en and blk_count==0, else WAIT_FIFO. start outside IDLE is ignored.
- WAIT_FIFO: fifo_ready -> BLOCK. No timeout here.
- BLOCK: blk_done with blk_crc_ok=0 sets crc_err -> END. blk_done with blk_crc_ok=1 decrements blocks_left if blk_cnt_en; write -> WAIT_BUSY, read -> NEXT.
- WAIT_BUSY: dat0_busy low -> NEXT.
- NEXT decision: last if !multi_blk, or (blk_cnt_en and blocks_left now 0), or stop_req. last -> END, else WAIT_FIFO.
- END: STOP_CMD if multi_blk and auto_cmd12_en, else DONE.
- STOP_CMD: cmd12_req=1; cmd12_ack -> DONE.
- DONE: xfer_done=1 for one cycle, then IDLE.
- Timeout: counter loads timeout_val on entry to BLOCK and WAIT_BUSY and decrements each clk. Reaching 0 with timeout_val!=0 sets timeout_err -> END.
- blk_done and timeout expiry in the same cycle: blk_done wins, no timeout_err.
- blocks_left never wraps below 0.
- soft_reset (any state) -> IDLE at next edge. Clears errors, blocks_left, and cmd12_req. No xfer_done pulse.

## Timing
- Reset values: state IDLE, all outputs 0, blocks_left 0, blk_len 0.
- All outputs are registered.
- start sampled at edge E: xfer_active=1 after E.
- fifo_ready sampled at edge F: blk_start=1 for the single cycle after F.
- blk_start is asserted exactly once per block.
- Read path: blk_done at edge D with more blocks remaining -> WAIT_FIFO after D. fifo_ready already high gives the next blk_start after D+1.
- Write path: blk_done -> WAIT_BUSY. Exit is 1 cycle after dat0_busy is sampled low.
- xfer_done is high for the cycle after entering DONE. xfer_active drops in the same cycle xfer_done drops.
- Reset mid-transfer: all outputs return to reset values asynchronously.

## Test plan
- Single-block read: blk_size=512, multi_blk=0, fifo_ready=1, blk_done+crc_ok -> exactly 1 blk_start, blk_len=512, xfer_done 1 cycle later, no cmd12_req.
- Multi-block write: blk_count=3, blk_cnt_en=1, auto_cmd12_en=1, dat0_busy 5 cycles per block -> 3 blk_start pulses, blocks_left 3->2->1->0, cmd12_req held until cmd12_ack, then xfer_done.
- CRC fail: block 2 of 4 with blk_crc_ok=0 -> crc_err=1, blocks_left=3, cmd12_req, xfer_done, no third blk_start.
- Timeout: timeout_val=10, blk_done never arrives -> timeout_err set 10 cycles after BLOCK entry. timeout_val=0 -> no error after 1000 cycles.
- Boundaries: blk_count=0 with blk_cnt_en=1 -> xfer_done with no blk_start. blk_done and timeout expiry in the same cycle -> no timeout_err. start while active -> ignored.
- Aborts: soft_reset mid-BLOCK -> IDLE next edge, errors cleared, no xfer_done. reset_n low mid-STOP_CMD -> cmd12_req=0 immediately.
